// File: rtl/cache_arbiter_rr_if.sv
// Request/response bundle between N L1 requesters, the round-robin arbiter
// and the shared lower-level memory port.
//   req_read/req_write  : per-port requests, held until that port's req_resp
//   req_address/wdata   : per-port payloads, port i in slice i
//   req_rdata/req_resp  : shared read data and one-hot completion pulse
//   mem_*               : downstream handshake (read/write held until mem_resp)
//   grant_id            : index of the granted / last-served port
// slave = arbiter view, master = requester + memory view.
interface cache_arbiter_rr_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
);
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]            req_resp;
    logic                            mem_read;
    logic                            mem_write;
    logic [ADDR_WIDTH-1:0]           mem_address;
    logic [LINE_WIDTH-1:0]           mem_wdata;
    logic                            mem_resp;
    logic [LINE_WIDTH-1:0]           mem_rdata;
    logic [GW-1:0]                   grant_id;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
        output req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, grant_id
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
        input  req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, grant_id
    );
endinterface

// File: rtl/cache_arbiter_rr.sv
// N-port round-robin arbiter from L1 requesters onto one shared memory port.
// One transaction in flight; IDLE -> BUSY (wait mem_resp) -> DONE (resp pulse).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : cache_arbiter_rr_if.slave (request side + memory side + grant_id)
// All outputs are registered.
module cache_arbiter_rr #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    cache_arbiter_rr_if.slave bus
);
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]   resp_q, resp_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;

    logic [NUM_PORTS-1:0]                 pending_c;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_arr_c;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] wdata_arr_c;
    logic [GW-1:0]                        gnt_c;
    logic                                 found_c;
    logic [GW-1:0]                        ptr_next_c;
    int unsigned                          idx;

    assign pending_c   = bus.req_read | bus.req_write;
    assign addr_arr_c  = bus.req_address;
    assign wdata_arr_c = bus.req_wdata;

    // Pointer after serving grant_q, wrapping at NUM_PORTS (stays 0 for one port).
    assign ptr_next_c = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);

    // First pending port at or after ptr; scanned far-to-near so the nearest wins.
    always_comb begin
        found_c = 1'b0;
        gnt_c   = '0;
        idx     = 0;
        for (int unsigned i = NUM_PORTS; i > 0; i--) begin
            idx = 32'(ptr_q) + i - 1;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (pending_c[GW'(idx)]) begin
                found_c = 1'b1;
                gnt_c   = GW'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = '0;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    grant_d     = gnt_c;
                    addr_d      = addr_arr_c[gnt_c];
                    wdata_d     = wdata_arr_c[gnt_c];
                    // Write takes priority when a port raises both.
                    mem_write_d = bus.req_write[gnt_c];
                    mem_read_d  = ~bus.req_write[gnt_c];
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_resp) begin
                    if (mem_read_q) rdata_d = bus.mem_rdata;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ptr_d       = ptr_next_c;
                    resp_d      = NUM_PORTS'(1) << grant_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign bus.req_rdata   = rdata_q;
    assign bus.req_resp    = resp_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.grant_id    = grant_q;
endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Self-checking bench: a 2-port and a 4-port arbiter, memory driven by the
// bench, completions checked against a scoreboard of expected responses.
module tb_cache_arbiter_rr;
    logic clk = 1'b0;
    logic reset2;
    logic reset4;

    always #5 clk = ~clk;

    cache_arbiter_rr_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) if2 ();
    cache_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) if4 ();

    cache_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) u_dut2 (
        .clk(clk), .reset(reset2), .bus(if2.slave)
    );
    cache_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) u_dut4 (
        .clk(clk), .reset(reset4), .bus(if4.slave)
    );

    typedef struct packed {
        logic [3:0]   resp;
        logic [127:0] rdata;
    } exp_t;

    exp_t sb2[$];
    exp_t sb4[$];
    exp_t e2;
    exp_t e4;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [127:0] last_rd2;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitors: every req_resp pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (if2.req_resp != '0) begin
            if (sb2.size() == 0) begin
                check("resp2_unexpected", 128'(if2.req_resp), 128'(0));
            end else begin
                e2 = sb2.pop_front();
                check("resp2_vec", 128'(if2.req_resp), 128'(e2.resp));
                check("resp2_rdata", if2.req_rdata, e2.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (if4.req_resp != '0) begin
            if (sb4.size() == 0) begin
                check("resp4_unexpected", 128'(if4.req_resp), 128'(0));
            end else begin
                e4 = sb4.pop_front();
                check("resp4_vec", 128'(if4.req_resp), 128'(e4.resp));
                check("resp4_rdata", if4.req_rdata, e4.rdata);
            end
        end
    end

    // Waits for a grant on the 2-port DUT, answers after `delay` BUSY cycles,
    // and returns in the DONE cycle with the bus values seen just before mem_resp.
    task automatic serve2(input int delay, input logic [127:0] data, input bit chg,
                          output logic rd, output logic wr, output logic [15:0] addr,
                          output logic [127:0] wd, output logic [0:0] gid);
        int n;
        rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; gid = '0;
        n = 0;
        tick();
        while (!(if2.mem_read || if2.mem_write) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            check("busy2_timeout", 128'(0), 128'(1));
        end else begin
            for (int i = 1; i < delay; i++) begin
                if (chg && i == 1) if2.req_address[15:0] = 16'hFFFF;
                tick();
            end
            rd = if2.mem_read; wr = if2.mem_write; addr = if2.mem_address;
            wd = if2.mem_wdata; gid = if2.grant_id;
            if2.mem_resp  = 1'b1;
            if2.mem_rdata = data;
            tick();
            if2.mem_resp  = 1'b0;
            if2.mem_rdata = 128'($urandom);
        end
    endtask

    logic         o_rd, o_wr;
    logic [15:0]  o_addr;
    logic [127:0] o_wd;
    logic [0:0]   o_gid;
    int           n4;

    initial begin
        if2.req_read = '0; if2.req_write = '0; if2.req_address = '0; if2.req_wdata = '0;
        if2.mem_resp = 1'b0; if2.mem_rdata = '0;
        if4.req_read = '0; if4.req_write = '0; if4.req_address = '0; if4.req_wdata = '0;
        if4.mem_resp = 1'b0; if4.mem_rdata = '0;
        reset2 = 1'b1; reset4 = 1'b1;
        last_rd2 = '0;
        repeat (3) tick();
        reset2 = 1'b0;
        tick();

        // Reset state
        check("rst_resp", 128'({if2.req_resp, if4.req_resp}), 128'(0));
        check("rst_memop", 128'({if2.mem_read, if2.mem_write, if4.mem_read, if4.mem_write}), 128'(0));
        check("rst_addr_gid", 128'({if2.mem_address, if2.grant_id, if4.grant_id}), 128'(0));
        check("rst_data", if2.mem_wdata | if2.req_rdata, 128'(0));

        // Port0 read, response two cycles into BUSY
        if2.req_read[0] = 1'b1; if2.req_address[15:0] = 16'h1234;
        last_rd2 = 128'h1CACE;
        sb2.push_back('{resp: 4'b0001, rdata: last_rd2});
        serve2(2, 128'h1CACE, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[0] = 1'b0;
        check("t1_rd", 128'({o_rd, o_wr}), 128'(2'b10));
        check("t1_addr", 128'(o_addr), 128'h1234);
        check("t1_gid", 128'(o_gid), 128'(0));
        tick();
        check("t1_resp_clear", 128'(if2.req_resp), 128'(0));

        // Port1 read+write together: write wins, rdata untouched (ptr is 1 here)
        if2.req_read[1] = 1'b1; if2.req_write[1] = 1'b1;
        if2.req_address[31:16] = 16'h4444; if2.req_wdata[255:128] = 128'h4444_0000;
        sb2.push_back('{resp: 4'b0010, rdata: last_rd2});
        serve2(1, 128'hBAD0_BAD0, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[1] = 1'b0; if2.req_write[1] = 1'b0;
        check("t6_op", 128'({o_rd, o_wr}), 128'(2'b01));
        check("t6_addr", 128'(o_addr), 128'h4444);
        tick();
        check("t6_rdata_kept", if2.req_rdata, last_rd2);

        // Simultaneous requests with ptr back at 0: port0 first, then port1 write
        if2.req_read[0] = 1'b1; if2.req_address[15:0] = 16'h5678;
        if2.req_write[1] = 1'b1; if2.req_address[31:16] = 16'h9ABC;
        if2.req_wdata[255:128] = 128'hDCACE;
        last_rd2 = 128'h2222;
        sb2.push_back('{resp: 4'b0001, rdata: last_rd2});
        serve2(1, 128'h2222, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[0] = 1'b0;
        check("t2a_gid", 128'(o_gid), 128'(0));
        check("t2a_addr", 128'(o_addr), 128'h5678);
        sb2.push_back('{resp: 4'b0010, rdata: last_rd2});
        serve2(1, 128'h3131, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_write[1] = 1'b0;
        check("t2b_gid", 128'(o_gid), 128'(1));
        check("t2b_op", 128'({o_rd, o_wr}), 128'(2'b01));
        check("t2b_addr", 128'(o_addr), 128'h9ABC);
        check("t2b_wdata", o_wd, 128'hDCACE);
        tick();

        // ptr wrapped to 0: a fresh simultaneous pair serves port0 first again
        if2.req_read = 2'b11;
        last_rd2 = 128'h0A0A;
        sb2.push_back('{resp: 4'b0001, rdata: last_rd2});
        serve2(1, 128'h0A0A, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[0] = 1'b0;
        check("t2c_gid", 128'(o_gid), 128'(0));
        last_rd2 = 128'h0B0B;
        sb2.push_back('{resp: 4'b0010, rdata: last_rd2});
        serve2(1, 128'h0B0B, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[1] = 1'b0;
        check("t2d_gid", 128'(o_gid), 128'(1));
        tick();

        // Reset in the second BUSY cycle of a port1 read: aborted, no response
        if2.req_read[1] = 1'b1; if2.req_address[31:16] = 16'h7777;
        tick();
        check("t4_busy", 128'({if2.mem_read, if2.grant_id}), 128'(2'b11));
        tick();
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0; if2.req_read[1] = 1'b0;
        last_rd2 = '0;
        check("t4_after", 128'({if2.mem_read, if2.mem_write, if2.req_resp, if2.grant_id}), 128'(0));
        check("t4_rdata", if2.req_rdata, 128'(0));
        tick();
        if2.req_read[1] = 1'b1; if2.req_address[31:16] = 16'h7778;
        last_rd2 = 128'h3333;
        sb2.push_back('{resp: 4'b0010, rdata: last_rd2});
        serve2(1, 128'h3333, 1'b0, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[1] = 1'b0;
        check("t4_regrant", 128'({o_gid, o_addr}), 128'({1'b1, 16'h7778}));
        tick();

        // mem_resp while IDLE is ignored
        if2.mem_resp = 1'b1; if2.mem_rdata = 128'hDEAD;
        tick();
        tick();
        check("t5_idle_resp", 128'({if2.req_resp, if2.mem_read, if2.mem_write}), 128'(0));
        check("t5_idle_rdata", if2.req_rdata, last_rd2);
        if2.mem_resp = 1'b0;
        tick();

        // Address changed mid-BUSY: the latched one stays on the bus
        if2.req_read[0] = 1'b1; if2.req_address[15:0] = 16'h1000;
        last_rd2 = 128'h4444;
        sb2.push_back('{resp: 4'b0001, rdata: last_rd2});
        serve2(3, 128'h4444, 1'b1, o_rd, o_wr, o_addr, o_wd, o_gid);
        if2.req_read[0] = 1'b0;
        check("t5_addr_stable", 128'(o_addr), 128'h1000);
        tick();

        // 4 ports, all requesting continuously, memory answers in the first BUSY cycle
        check("t3_rst_gid", 128'({if4.grant_id, if4.mem_read}), 128'(0));
        reset4 = 1'b0;
        if4.req_address = {16'h0303, 16'h0202, 16'h0101, 16'h0000};
        if4.req_read = 4'hF;
        for (int t = 0; t < 6; t++) begin
            n4 = 0;
            tick();
            while (!if4.mem_read && n4 < 20) begin
                tick();
                n4++;
            end
            if (n4 >= 20) check("t3_timeout", 128'(0), 128'(1));
            check("t3_gid", 128'(if4.grant_id), 128'(t % 4));
            check("t3_addr", 128'(if4.mem_address), 128'((t % 4) * 16'h0101));
            sb4.push_back('{resp: 4'(1 << (t % 4)), rdata: 128'(32'hA0 + t)});
            if4.mem_resp = 1'b1; if4.mem_rdata = 128'(32'hA0 + t);
            tick();
            if4.mem_resp = 1'b0;
        end
        if4.req_read = '0;
        repeat (4) tick();

        check("sb2_empty", 128'(sb2.size()), 128'(0));
        check("sb4_empty", 128'(sb4.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
